mem_loader: RTL
===============

Name: mem_loader

Overview:
- Host-side program/data loader for Single_Cycle_RISC.
- Drives the CPU's external memory write interface, which the CPU receives: test_normal, ext_instr_we/addr/data, ext_data_we/addr/data.
- Parses a byte-stream command protocol (valid/ready), writes instruction or data words, then releases the CPU to run.
- Detects HLT via the CPU's done output and returns to load mode.

Parameters:
- TIMEOUT, 1000, max idle cycles between bytes of one frame before the frame is aborted; 0 disables the timeout.
- DONE_ACTIVE_LOW, 1, 1 means done=0 signals halt; 0 means done=1 signals halt.

Ports:
- clk  in  1  system clock, rising edge.
- clr_n  in  1  asynchronous active-low reset (asynchronous assert, synchronous release).
- in_valid  in  1  host byte valid.
- in_data  in  8  host byte.
- in_ready  out  1  loader accepts byte; a transfer occurs when in_valid&in_ready at a clk edge.
- done  in  1  CPU halt indicator; polarity per DONE_ACTIVE_LOW.
- test_normal  out  1  1 = load mode (external writes), 0 = CPU runs.
- cpu_clr  out  1  active-high CPU clear, one-cycle pulse.
- ext_instr_we  out  1  instruction memory write strobe.
- ext_instr_addr  out  16  instruction write address.
- ext_instr_data  out  16  instruction write data.
- ext_data_we  out  1  data memory write strobe.
- ext_data_addr  out  16  data write address.
- ext_data_data  out  16  data write data.
- busy  out  1  CPU running.
- halted  out  1  sticky; set on halt, cleared when the next RUN starts.
- err  out  1  sticky; set on bad command or timeout, cleared by command 0x00.
- wr_count  out  16  completed memory writes, wraps at 0xFFFF.
- run_cycles  out  16  cycles in RUN, saturates at 0xFFFF.

Behaviour:
- Reset values: test_normal=1; all other outputs 0; state=CMD.
- Frame format: CMD byte, then for write commands ADDR_H, ADDR_L, DATA_H, DATA_L (big-endian).
- CMD 0x01: write instruction word.
- CMD 0x02: write data word.
- CMD 0x03: RUN.
- CMD 0x00: NOP; clears err.
- Any other CMD: set err, stay in CMD.
- States: CMD, ADDR_H, ADDR_L, DATA_H, DATA_L, WRITE, CLR, RUN.
  - in_ready=1 only in CMD, ADDR_H, ADDR_L, DATA_H, DATA_L.
- Address/data latching: the addr/data registers for the selected memory update as each byte is accepted. The non-selected memory's registers hold their values.
- WRITE state:
  - Exactly one cycle, entered the cycle after DATA_L is accepted.
  - Asserts the selected we for that one cycle, with addr/data already stable.
  - wr_count++, then go to CMD.
  - Throughput: one write per 6 cycles minimum.
- RUN command:
  - CMD→CLR: test_normal=0, cpu_clr=1 for one cycle, halted cleared, run_cycles cleared.
  - CLR→RUN: busy=1; run_cycles increments every RUN cycle, saturating.
- Halt detection:
  - The done halt level is sampled from the second RUN cycle onward.
  - On halt: busy=0, halted=1, test_normal=1, go to CMD.
  - A halt level during CLR or the first RUN cycle is ignored, because the CPU is still clearing.
- Timeout:
  - In ADDR_H..DATA_L, an idle counter resets on each accepted byte.
  - When it reaches TIMEOUT: set err, discard the partial frame, go to CMD. No write occurs.
- Writes never occur while test_normal=0.
- Reset mid-operation (any state, including mid-RUN): immediate return to reset values; the partial frame is lost.
- The err and halted flags are independent, so both may be 1 at once.

Decomposition:
- Package mem_loader_pkg: command codes (CMD_NOP=0x00, CMD_WI=0x01, CMD_WD=0x02, CMD_RUN=0x03) and the state encoding enum.
- No sub-module; the timeout counter is inline.

Test Plan:
- Send 01 00 03 00 C8 → ext_instr_we high exactly one cycle with addr=0x0003, data=0x00C8; wr_count=1; ext_data_we never asserts.
- Send 02 00 25 00 47, then 03; CPU model raises halt after 50 cycles → ext_data_we pulse at addr 0x0025 with data 0x0047. On RUN: test_normal falls, cpu_clr pulses one cycle, busy=1. On halt: test_normal=1, halted=1, run_cycles≈50.
- Send 01 00 then idle for TIMEOUT cycles → err=1, no write strobe, state CMD. Then send 00 → err=0.
- Send 7F → err=1, in_ready stays 1. Then a valid 01 frame → the write completes normally.
- Hold in_valid=1 with back-to-back frames → in_ready low during WRITE, no byte lost, wr_count matches the number of frames.
- Assert clr_n=0 mid-RUN → test_normal=1, busy=0, cpu_clr=0, all counters 0, within the same cycle (asynchronous).

Source files
------------

// File: rtl/mem_loader_pkg.sv
// mem_loader shared definitions.
// Command codes and FSM state encoding.
package mem_loader_pkg;

  localparam logic [7:0] CMD_NOP = 8'h00;
  localparam logic [7:0] CMD_WI  = 8'h01;
  localparam logic [7:0] CMD_WD  = 8'h02;
  localparam logic [7:0] CMD_RUN = 8'h03;

  typedef enum logic [2:0] {
    S_CMD,
    S_ADDR_H,
    S_ADDR_L,
    S_DATA_H,
    S_DATA_L,
    S_WRITE,
    S_CLR,
    S_RUN
  } state_t;

endpackage

// File: rtl/mem_loader.sv
// mem_loader: byte-stream program/data loader.
// Fills CPU memories, then runs the CPU until halt.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int TIMEOUT         = 1000,
  parameter bit DONE_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        done,
  output logic        test_normal,
  output logic        cpu_clr,
  output logic        ext_instr_we,
  output logic [15:0] ext_instr_addr,
  output logic [15:0] ext_instr_data,
  output logic        ext_data_we,
  output logic [15:0] ext_data_addr,
  output logic [15:0] ext_data_data,
  output logic        busy,
  output logic        halted,
  output logic        err,
  output logic [15:0] wr_count,
  output logic [15:0] run_cycles
);

  localparam logic [31:0] TO_M1 =
    (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  state_t      state;
  logic        sel_data;
  logic        run_first;
  logic        rst_q1;
  logic        rst_q2;
  logic [31:0] idle;
  logic        take;
  logic        in_frame;
  logic        halt_lvl;
  logic        to_hit;

  assign in_frame = (state == S_ADDR_H) ||
                    (state == S_ADDR_L) ||
                    (state == S_DATA_H) ||
                    (state == S_DATA_L);

  assign in_ready = rst_q2 &&
                    (in_frame || (state == S_CMD));

  assign take     = in_valid && in_ready;
  assign halt_lvl = DONE_ACTIVE_LOW ? ~done : done;
  assign to_hit   = (TIMEOUT != 0) && in_frame &&
                    !take && (idle == TO_M1);

  assign test_normal  = !((state == S_CLR) ||
                          (state == S_RUN));
  assign cpu_clr      = (state == S_CLR);
  assign busy         = (state == S_RUN);
  assign ext_instr_we = (state == S_WRITE) && !sel_data;
  assign ext_data_we  = (state == S_WRITE) && sel_data;

  // Reset release synchroniser; gates byte acceptance.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rst_q1 <= 1'b0;
      rst_q2 <= 1'b0;
    end else begin
      rst_q1 <= 1'b1;
      rst_q2 <= rst_q1;
    end
  end

  // Inter-byte idle counter, live only inside a frame.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      idle <= '0;
    end else if (!in_frame || take) begin
      idle <= '0;
    end else if (idle != '1) begin
      idle <= idle + 32'd1;
    end
  end

  // Command parser, write sequencer and run control.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state          <= S_CMD;
      sel_data       <= 1'b0;
      run_first      <= 1'b0;
      halted         <= 1'b0;
      err            <= 1'b0;
      wr_count       <= '0;
      run_cycles     <= '0;
      ext_instr_addr <= '0;
      ext_instr_data <= '0;
      ext_data_addr  <= '0;
      ext_data_data  <= '0;
    end else begin
      unique case (state)
        S_CMD: begin
          if (take) begin
            unique case (1'b1)
              (in_data == CMD_NOP): err <= 1'b0;
              (in_data == CMD_WI): begin
                sel_data <= 1'b0;
                state    <= S_ADDR_H;
              end
              (in_data == CMD_WD): begin
                sel_data <= 1'b1;
                state    <= S_ADDR_H;
              end
              (in_data == CMD_RUN): begin
                halted     <= 1'b0;
                run_cycles <= '0;
                state      <= S_CLR;
              end
              default: err <= 1'b1;
            endcase
          end
        end
        S_ADDR_H: begin
          if (take) begin
            if (sel_data) ext_data_addr[15:8] <= in_data;
            else          ext_instr_addr[15:8] <= in_data;
            state <= S_ADDR_L;
          end else if (to_hit) begin
            err   <= 1'b1;
            state <= S_CMD;
          end
        end
        S_ADDR_L: begin
          if (take) begin
            if (sel_data) ext_data_addr[7:0] <= in_data;
            else          ext_instr_addr[7:0] <= in_data;
            state <= S_DATA_H;
          end else if (to_hit) begin
            err   <= 1'b1;
            state <= S_CMD;
          end
        end
        S_DATA_H: begin
          if (take) begin
            if (sel_data) ext_data_data[15:8] <= in_data;
            else          ext_instr_data[15:8] <= in_data;
            state <= S_DATA_L;
          end else if (to_hit) begin
            err   <= 1'b1;
            state <= S_CMD;
          end
        end
        S_DATA_L: begin
          if (take) begin
            if (sel_data) ext_data_data[7:0] <= in_data;
            else          ext_instr_data[7:0] <= in_data;
            state <= S_WRITE;
          end else if (to_hit) begin
            err   <= 1'b1;
            state <= S_CMD;
          end
        end
        S_WRITE: begin
          wr_count <= wr_count + 16'd1;
          state    <= S_CMD;
        end
        S_CLR: begin
          run_first <= 1'b1;
          state     <= S_RUN;
        end
        S_RUN: begin
          run_first <= 1'b0;
          if (run_cycles != 16'hFFFF)
            run_cycles <= run_cycles + 16'd1;
          if (!run_first && halt_lvl) begin
            halted <= 1'b1;
            state  <= S_CMD;
          end
        end
        default: state <= S_CMD;
      endcase
    end
  end

endmodule
